crc_calc: RTL and testbench
===========================

# crc_calc

Parameterized CRC engine for the data-path integrity logic: a purely combinational next-CRC function (data word plus current CRC gives updated CRC) and a clocked accumulator built on the same function. Any polynomial is supported, with any CRC width and any data width. The combinational path lets a parent keep its own CRC register. The built-in accumulator serves streams that need no external state.

## Interface
Parameters:
- DATAWIDTH, 8: bits of i_dat consumed per update (≥1; may exceed CRCWIDTH).
- CRCWIDTH, 16: CRC register width (≥1).
- POLYNOMIAL, 16'h8005: generator polynomial, normal (non-reflected) form, implicit x^CRCWIDTH term omitted.
- INIT, 16'h0000: accumulator value after reset or clear.

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous active-high reset of the accumulator.
- i_dat  in  DATAWIDTH  data word for both paths.
- i_crc  in  CRCWIDTH  current CRC for the combinational path.
- o_crc  out  CRCWIDTH  combinational next CRC = F(i_crc, i_dat).
- i_clkena  in  1  accumulator update enable.
- i_clear  in  1  synchronous reload of accumulator to INIT.
- o_acc  out  CRCWIDTH  accumulator register value.

## Operation
- F(c, d) is the bit-serial MSB-first CRC unrolled over DATAWIDTH steps.
- Bits are processed from d[DATAWIDTH-1] down to d[0].
- Each step: fb = c[CRCWIDTH-1] ^ d[k]; c = (c << 1) truncated to CRCWIDTH; if fb, c ^= POLYNOMIAL.
- There is no input or output reflection and no final XOR. Reflected standards are built by the parent through bit reversal of the data and the result.
- F is linear over GF(2): F(0,0)=0 and F(a^b, x^y) = F(a,x) ^ F(b,y).
- o_crc depends only on i_crc and i_dat. It has no clock dependency and is unaffected by reset.
- Accumulator priority: reset (async) > i_clear > i_clkena > hold.
  - i_clear: o_acc ← INIT, regardless of i_clkena.
  - i_clkena: o_acc ← F(o_acc, i_dat).
  - Otherwise: o_acc holds.
- X/unknown handling: none required. Inputs are assumed driven.

## Timing
- o_crc: zero latency, purely combinational, and it settles within one cycle of the target clock.
- o_acc:
  - Updates on the rising edge of clk when i_clkena=1, so the result for a word appears the cycle after it is presented.
  - Back-to-back words are accepted every cycle.
- Reset:
  - o_acc = INIT immediately on reset assertion, asynchronously.
  - It stays at INIT while reset is high.
  - The first update can occur on the first rising edge after deassertion.
- Reset mid-stream discards the partial CRC.
- Simultaneous i_clear and i_clkena: clear wins and the data word is dropped.

## Structure
- Package crc_calc_pkg:
  - Function crc_step(c, d, poly) for a single bit.
  - Function crc_word(c, d, poly), unrolled loop over DATAWIDTH, usable by other blocks.
- Sub-module crc_calculator (combinational, ports i_dat/i_crc/o_crc, params DATAWIDTH/CRCWIDTH/POLYNOMIAL). Instantiate it twice:
  - once for o_crc;
  - once with i_crc=o_acc to feed the accumulator.
- Top crc_calc holds only the accumulator register and the control priority.

## Test plan
- i_crc=0x0000, i_dat=0x00 -> o_crc=0x0000. i_crc=0x0000, i_dat=0x01 -> o_crc=0x8005.
- Reset, then i_clkena=1 over ASCII "123456789" (0x31..0x39), one byte per cycle -> o_acc=0xFEE8 (CRC-16/BUYPASS).
- Same stream with each byte bit-reversed before i_dat, and o_acc bit-reversed at the end -> 0xBB3D (CRC-16/ARC).
- Stream with i_clkena gaps of 1–3 cycles, data toggling during gaps -> same final 0xFEE8; o_acc constant during gaps.
- Assert reset asynchronously (between clock edges) mid-stream -> o_acc=0x0000 at once. Assert i_clear together with i_clkena -> o_acc=INIT next cycle and the word is ignored.
- Randomized i_crc/i_dat (≥10k vectors) against a bit-serial reference model; repeat with DATAWIDTH=32, CRCWIDTH=32, POLYNOMIAL=32'h04C11DB7 -> exact match, plus a linearity check.

Source files
------------

// File: rtl/crc_calc_pkg.sv
// Shared CRC helpers: single-bit MSB-first CRC step and a word-wide unrolled update.
// Widths are carried as arguments so one pair of functions serves every instance.
package crc_calc_pkg;

    localparam int CRC_MAX_W = 64;
    localparam int DAT_MAX_W = 64;

    function automatic logic [CRC_MAX_W-1:0] crc_step(
        input logic [CRC_MAX_W-1:0] c,
        input logic                 d,
        input logic [CRC_MAX_W-1:0] poly,
        input int                   crc_w
    );
        logic [CRC_MAX_W-1:0] mask;
        logic [CRC_MAX_W-1:0] nxt;
        logic                 fb;
        // Full-width shift wraps to zero, so the mask becomes all ones when crc_w == CRC_MAX_W.
        mask = (CRC_MAX_W'(1) << crc_w) - CRC_MAX_W'(1);
        fb   = (|(c & (CRC_MAX_W'(1) << (crc_w - 1)))) ^ d;
        nxt  = (c << 1) & mask;
        if (fb) begin
            nxt = nxt ^ (poly & mask);
        end
        return nxt;
    endfunction

    function automatic logic [CRC_MAX_W-1:0] crc_word(
        input logic [CRC_MAX_W-1:0] c,
        input logic [DAT_MAX_W-1:0] d,
        input logic [CRC_MAX_W-1:0] poly,
        input int                   crc_w,
        input int                   dat_w
    );
        logic [CRC_MAX_W-1:0] acc;
        acc = c;
        for (int k = DAT_MAX_W - 1; k >= 0; k--) begin
            if (k < dat_w) begin
                acc = crc_step(acc, |(d & (DAT_MAX_W'(1) << k)), poly, crc_w);
            end
        end
        return acc;
    endfunction

endpackage

// File: rtl/crc_calc_calculator.sv
// Combinational next-CRC: o_crc = F(i_crc, i_dat), data consumed MSB first.
module crc_calculator
    import crc_calc_pkg::*;
#(
    parameter int                  DATAWIDTH  = 8,
    parameter int                  CRCWIDTH   = 16,
    parameter logic [CRCWIDTH-1:0] POLYNOMIAL = 16'h8005
) (
    input  logic [DATAWIDTH-1:0] i_dat,
    input  logic [CRCWIDTH-1:0]  i_crc,
    output logic [CRCWIDTH-1:0]  o_crc
);

    assign o_crc = CRCWIDTH'(crc_word(CRC_MAX_W'(i_crc), DAT_MAX_W'(i_dat),
                                      CRC_MAX_W'(POLYNOMIAL), CRCWIDTH, DATAWIDTH));

endmodule

// File: rtl/crc_calc.sv
// CRC engine top: combinational next-CRC path plus a clocked accumulator on the same function.
module crc_calc
    import crc_calc_pkg::*;
#(
    parameter int                  DATAWIDTH  = 8,
    parameter int                  CRCWIDTH   = 16,
    parameter logic [CRCWIDTH-1:0] POLYNOMIAL = 16'h8005,
    parameter logic [CRCWIDTH-1:0] INIT       = 16'h0000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATAWIDTH-1:0] i_dat,
    input  logic [CRCWIDTH-1:0]  i_crc,
    output logic [CRCWIDTH-1:0]  o_crc,
    input  logic                 i_clkena,
    input  logic                 i_clear,
    output logic [CRCWIDTH-1:0]  o_acc
);

    logic [CRCWIDTH-1:0] acc_q;
    logic [CRCWIDTH-1:0] acc_d;
    logic [CRCWIDTH-1:0] acc_next;

    crc_calculator #(
        .DATAWIDTH (DATAWIDTH),
        .CRCWIDTH  (CRCWIDTH),
        .POLYNOMIAL(POLYNOMIAL)
    ) u_comb (
        .i_dat(i_dat),
        .i_crc(i_crc),
        .o_crc(o_crc)
    );

    crc_calculator #(
        .DATAWIDTH (DATAWIDTH),
        .CRCWIDTH  (CRCWIDTH),
        .POLYNOMIAL(POLYNOMIAL)
    ) u_acc (
        .i_dat(i_dat),
        .i_crc(acc_q),
        .o_crc(acc_next)
    );

    // Clear outranks enable: a word presented alongside a clear is dropped.
    always_comb begin
        acc_d = acc_q;
        if (i_clear) begin
            acc_d = INIT;
        end else if (i_clkena) begin
            acc_d = acc_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q <= INIT;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign o_acc = acc_q;

endmodule

// File: tb/tb_crc_calc.sv
// Self-checking bench for crc_calc: known-answer vectors, CRC-16 standards, control corner cases,
// and randomized checks against a polynomial-division reference for 16- and 32-bit configurations.
module tb_crc_calc;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [7:0]  dat16;
    logic [15:0] icrc16, ocrc16, acc16;
    logic        ena16, clr16;
    logic [31:0] dat32, icrc32, ocrc32, acc32;
    logic        ena32, clr32;

    int n_cmp  = 0;
    int n_fail = 0;

    crc_calc dut16 (
        .clk(clk), .reset(rst), .i_dat(dat16), .i_crc(icrc16), .o_crc(ocrc16),
        .i_clkena(ena16), .i_clear(clr16), .o_acc(acc16)
    );

    crc_calc #(
        .DATAWIDTH(32), .CRCWIDTH(32), .POLYNOMIAL(32'h04C11DB7), .INIT(32'h0)
    ) dut32 (
        .clk(clk), .reset(rst), .i_dat(dat32), .i_crc(icrc32), .o_crc(ocrc32),
        .i_clkena(ena32), .i_clear(clr32), .o_acc(acc32)
    );

    // Reference: remainder of (c * x^dw + d * x^cw) divided by the full generator polynomial.
    function automatic logic [63:0] ref_crc(input logic [63:0] c, input logic [63:0] d,
                                            input int cw, input int dw, input logic [63:0] poly);
        logic [127:0] m;
        logic [127:0] g;
        m = ({64'b0, c} << dw) ^ ({64'b0, d} << cw);
        g = {64'b0, poly} | (128'b1 << cw);
        for (int i = cw + dw - 1; i >= cw; i--) begin
            if (m[i]) m = m ^ (g << (i - cw));
        end
        m = m & ((128'b1 << cw) - 128'b1);
        return m[63:0];
    endfunction

    function automatic logic [15:0] ref16(input logic [15:0] c, input logic [7:0] d);
        logic [63:0] r;
        r = ref_crc({48'b0, c}, {56'b0, d}, 16, 8, 64'h8005);
        return r[15:0];
    endfunction

    function automatic logic [31:0] ref32(input logic [31:0] c, input logic [31:0] d);
        logic [63:0] r;
        r = ref_crc({32'b0, c}, {32'b0, d}, 32, 32, 64'h04C11DB7);
        return r[31:0];
    endfunction

    function automatic logic [7:0] rev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7-i];
        return r;
    endfunction

    function automatic logic [15:0] rev16(input logic [15:0] v);
        logic [15:0] r;
        for (int i = 0; i < 16; i++) r[i] = v[15-i];
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Present one word with enable for exactly one rising edge; returns at edge + 1.
    task automatic feed(input logic [7:0] b);
        dat16 = b;
        ena16 = 1'b1;
        @(posedge clk);
        #1;
        ena16 = 1'b0;
    endtask

    task automatic clear_acc();
        clr16 = 1'b1;
        @(posedge clk);
        #1;
        clr16 = 1'b0;
    endtask

    typedef struct {
        logic [15:0] crc;
        logic [7:0]  dat;
        logic [15:0] exp;
    } vec_t;

    vec_t tbl[6];

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not finish, got running, expected done");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] m;
        logic [15:0] c16;
        logic [7:0]  d8;
        logic [31:0] a, b, x, y, ya, yb;
        int          g;

        tbl[0] = '{16'h0000, 8'h00, 16'h0000};
        tbl[1] = '{16'h0000, 8'h01, 16'h8005};
        tbl[2] = '{16'h0000, 8'h02, 16'h800F};
        tbl[3] = '{16'h0001, 8'h00, 16'h0100};
        tbl[4] = '{16'h0100, 8'h00, 16'h8005};
        tbl[5] = '{16'h0100, 8'h01, 16'h0000};

        rst = 1'b1;
        dat16 = '0; icrc16 = '0; ena16 = 1'b0; clr16 = 1'b0;
        dat32 = '0; icrc32 = '0; ena32 = 1'b0; clr32 = 1'b0;

        #3;
        check("reset_acc", {48'b0, acc16}, 64'h0);
        dat16 = 8'h01;
        #1;
        check("ocrc_during_reset", {48'b0, ocrc16}, 64'h8005);
        dat16 = 8'h00;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("acc_after_release", {48'b0, acc16}, 64'h0);

        for (int i = 0; i < 6; i++) begin
            icrc16 = tbl[i].crc;
            dat16  = tbl[i].dat;
            #1;
            check($sformatf("table_%0d", i), {48'b0, ocrc16}, {48'b0, tbl[i].exp});
        end
        icrc16 = '0;

        for (int i = 0; i < 9; i++) feed(8'h31 + 8'(i));
        check("buypass", {48'b0, acc16}, 64'hFEE8);

        clear_acc();
        check("clear", {48'b0, acc16}, 64'h0);
        for (int i = 0; i < 9; i++) feed(rev8(8'h31 + 8'(i)));
        check("arc", {48'b0, rev16(acc16)}, 64'hBB3D);

        clear_acc();
        m = 16'h0;
        for (int i = 0; i < 9; i++) begin
            feed(8'h31 + 8'(i));
            m = ref16(m, 8'h31 + 8'(i));
            g = $urandom_range(1, 3);
            for (int j = 0; j < g; j++) begin
                dat16 = 8'($urandom);
                @(posedge clk);
                #1;
                check("gap_hold", {48'b0, acc16}, {48'b0, m});
            end
        end
        check("gap_final", {48'b0, acc16}, 64'hFEE8);

        clear_acc();
        m = 16'h0;
        for (int i = 0; i < 3; i++) begin
            feed(8'h31 + 8'(i));
            m = ref16(m, 8'h31 + 8'(i));
        end
        check("pre_reset_partial", {48'b0, acc16}, {48'b0, m});
        #2;
        rst = 1'b1;
        #1;
        check("async_reset_now", {48'b0, acc16}, 64'h0);
        ena16 = 1'b1;
        dat16 = 8'h55;
        @(posedge clk);
        #1;
        check("held_in_reset", {48'b0, acc16}, 64'h0);
        rst = 1'b0;
        ena16 = 1'b0;
        for (int i = 0; i < 9; i++) feed(8'h31 + 8'(i));
        check("after_reset_stream", {48'b0, acc16}, 64'hFEE8);

        feed(8'h31);
        feed(8'h32);
        dat16 = 8'hA5;
        clr16 = 1'b1;
        ena16 = 1'b1;
        @(posedge clk);
        #1;
        clr16 = 1'b0;
        ena16 = 1'b0;
        check("clear_beats_enable", {48'b0, acc16}, 64'h0);
        for (int i = 0; i < 9; i++) feed(8'h31 + 8'(i));
        check("after_clear_stream", {48'b0, acc16}, 64'hFEE8);

        clear_acc();
        m = 16'h0;
        for (int i = 0; i < 300; i++) begin
            d8    = 8'($urandom);
            dat16 = d8;
            ena16 = ($urandom_range(0, 3) != 0);
            clr16 = ($urandom_range(0, 19) == 0);
            if (clr16) m = 16'h0;
            else if (ena16) m = ref16(m, d8);
            @(posedge clk);
            #1;
            check("rand_acc", {48'b0, acc16}, {48'b0, m});
        end
        ena16 = 1'b0;
        clr16 = 1'b0;

        for (int i = 0; i < 10000; i++) begin
            c16    = 16'($urandom);
            d8     = 8'($urandom);
            icrc16 = c16;
            dat16  = d8;
            #1;
            check("rand_comb16", {48'b0, ocrc16}, {48'b0, ref16(c16, d8)});
        end

        for (int i = 0; i < 10000; i++) begin
            a      = $urandom;
            x      = $urandom;
            icrc32 = a;
            dat32  = x;
            #1;
            check("rand_comb32", {32'b0, ocrc32}, {32'b0, ref32(a, x)});
        end

        icrc32 = '0;
        dat32  = 32'h0;
        #1;
        check("zero32", {32'b0, ocrc32}, 64'h0);
        for (int i = 0; i < 200; i++) begin
            a = $urandom; b = $urandom; x = $urandom; y = $urandom;
            icrc32 = a; dat32 = x;
            #1;
            ya = ocrc32;
            icrc32 = b; dat32 = y;
            #1;
            yb = ocrc32;
            icrc32 = a ^ b; dat32 = x ^ y;
            #1;
            check("linearity32", {32'b0, ocrc32}, {32'b0, ref32(a, x) ^ ref32(b, y)});
            check("linearity32_self", {32'b0, ocrc32}, {32'b0, ya ^ yb});
        end

        check("acc32_idle", {32'b0, acc32}, 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
